biu_arb: RTL and testbench
==========================

BIU_ARB -- requirements
Module: biu_arb

Interface
REQ-001 SHALL have parameters: AW, default 32, address width; DW, default 32, data width (multiple of 8); MEM_LAT, default 1, memory read latency in cycles (1..4); RSP_DEPTH, default 2, per-channel response FIFO depth (power of two, >=2).
REQ-002 SHALL have ports, one clock and synchronous active-high reset:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu2biu_req_vld  in  1  fetch request valid
- ifu2biu_req_rdy  out  1  fetch request accepted
- ifu2biu_req_pc  in  AW  fetch address
- biu2ifu_rsp_vld  out  1  instruction valid
- biu2ifu_rsp_rdy  in  1  IFU takes instruction
- biu2ifu_rsp_inst  out  DW  instruction
- lsu2biu_req_vld  in  1  load/store request valid
- lsu2biu_req_rdy  out  1  load/store request accepted
- lsu2biu_req_addr  in  AW  data address
- lsu2biu_req_wen  in  1  1=store, 0=load
- lsu2biu_req_wdata  in  DW  store data
- lsu2biu_req_wstrb  in  DW/8  store byte enables
- biu2lsu_rsp_vld  out  1  load data / store ack valid
- biu2lsu_rsp_rdy  in  1  LSU takes response
- biu2lsu_rsp_rdata  out  DW  load data (0 for store ack)
- addr  out  AW  memory address
- rdata  in  DW  memory read data
- wdata  out  DW  memory write data
- wen  out  1  memory write enable
- wstrb  out  DW/8  memory byte enables

Function
REQ-003 Request transfer SHALL occur on a channel when req_vld & req_rdy at a rising edge; at most one transfer per cycle over both channels.
REQ-004 req_rdy SHALL be high only for the granted channel; a channel is eligible iff its credit = RSP_DEPTH - (FIFO occupancy + in-flight requests for that channel) > 0.
REQ-005 Arbitration SHALL be round-robin: one eligible requester wins; both eligible -> channel not granted last; pointer updates only on transfer; after reset LSU wins first tie.
REQ-006 In the transfer cycle SHALL drive addr = req_pc/req_addr; for LSU wen = req_wen, wdata = req_wdata, wstrb = req_wstrb; for IFU wen=0, wdata=0, wstrb=0; no transfer -> addr, wdata, wstrb, wen all 0.
REQ-007 Accepted request SHALL enter a MEM_LAT-stage tag pipeline carrying {valid, channel, is_write}; rdata for a transfer at cycle T is sampled at cycle T+MEM_LAT.
REQ-008 At tag-pipeline exit SHALL push into that channel's response FIFO: rdata for reads, 0 for writes; rsp_vld asserts earliest at T+MEM_LAT+1.
REQ-009 Response pop SHALL occur when rsp_vld & rsp_rdy; rsp_inst/rsp_rdata show FIFO head, held stable while rsp_vld & ~rsp_rdy.
REQ-010 Responses per channel SHALL return in request order; channels are independent (IFU backpressure never stalls LSU responses).
REQ-011 Simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo RSP_DEPTH; credit rule guarantees no push into a full FIFO (assertion required).
REQ-012 Empty FIFO SHALL give rsp_vld=0 and data 0; a channel with zero credit SHALL see req_rdy=0 even if the other channel is idle.

Reset
REQ-013 rst high at a rising edge SHALL clear tag pipeline, FIFO pointers/occupancy, in-flight counts, and set RR pointer to favour LSU.
REQ-014 During/after reset all outputs SHALL be 0 until the next transfer; reset mid-operation discards in-flight requests and buffered responses without emitting them.

Structure
REQ-015 Package biu_pkg SHALL hold channel enum (CH_IFU, CH_LSU) and tag struct {vld, ch, is_write}.
REQ-016 Sub-module biu_rsp_fifo (DW, RSP_DEPTH; push/pop/data/count) SHALL be instantiated once per channel; arbiter and tag pipeline in biu_arb.

Verification
REQ-017 Single fetch, MEM_LAT=1: pc=0x100, rdata=0x00000013 at T+1 -> biu2ifu_rsp_vld at T+2, inst=0x00000013.
REQ-018 Both vld continuously, rsp_rdy=1: grants alternate LSU,IFU,LSU,IFU from reset; one wen=0 fetch addr per IFU grant.
REQ-019 IFU rsp_rdy=0, RSP_DEPTH=2: two fetches accepted, third cycle ifu2biu_req_rdy=0; LSU loads still accepted and returned.
REQ-020 Store addr=0x200, wdata=0xDEADBEEF, wstrb=0xF -> wen=1, wstrb=0xF same cycle; ack rsp_rdata=0 at T+MEM_LAT+1.
REQ-021 MEM_LAT=3, four back-to-back loads with rdata 1,2,3,4 -> responses 1,2,3,4 in order, occupancy never exceeds 2.
REQ-022 rst asserted with two in-flight and one buffered -> next cycle all rsp_vld=0; first new request returns only its own data.

Source files
------------

// File: rtl/biu_pkg.sv
// Shared types for the bus interface unit: the channel identifier and the
// tag that travels alongside each accepted request while memory responds.
package biu_pkg;

  typedef enum logic {
    CH_IFU = 1'b0,
    CH_LSU = 1'b1
  } ch_e;

  typedef struct packed {
    logic vld;
    ch_e  ch;
    logic is_write;
  } tag_t;

endpackage

// File: rtl/biu_rsp_fifo.sv
// Per-channel response FIFO.
// Ports: clk, rst (sync, active high); push_i/data_i write side;
//        pop_i/data_o read side (data_o is the head, 0 when empty);
//        count_o current occupancy.
module biu_rsp_fifo #(
  parameter int unsigned DW        = 32,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [DW-1:0]                  data_i,
  input  logic                           pop_i,
  output logic [DW-1:0]                  data_o,
  output logic [$clog2(RSP_DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(RSP_DEPTH);
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  logic [DW-1:0] mem_q [RSP_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  // Storage carries no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // Upstream credit accounting must never let a push hit a full FIFO.
      assert (!(push_i && (count_q == CW'(RSP_DEPTH)) && !do_pop));
    end
  end

endmodule

// File: rtl/biu_arb.sv
// Bus interface unit arbiter: round-robin between instruction fetch and
// load/store requests onto one memory port, tracks each accepted request
// through a MEM_LAT-deep tag pipeline and returns responses in order per
// channel through independent response FIFOs.
// Ports: clk, rst (sync, active high);
//        ifu2biu_req_* / biu2ifu_rsp_*  fetch request / instruction return;
//        lsu2biu_req_* / biu2lsu_rsp_*  load-store request / data return;
//        addr, wdata, wen, wstrb, rdata  memory port.
module biu_arb
  import biu_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu2biu_req_vld,
  output logic            ifu2biu_req_rdy,
  input  logic [AW-1:0]   ifu2biu_req_pc,
  output logic            biu2ifu_rsp_vld,
  input  logic            biu2ifu_rsp_rdy,
  output logic [DW-1:0]   biu2ifu_rsp_inst,
  input  logic            lsu2biu_req_vld,
  output logic            lsu2biu_req_rdy,
  input  logic [AW-1:0]   lsu2biu_req_addr,
  input  logic            lsu2biu_req_wen,
  input  logic [DW-1:0]   lsu2biu_req_wdata,
  input  logic [DW/8-1:0] lsu2biu_req_wstrb,
  output logic            biu2lsu_rsp_vld,
  input  logic            biu2lsu_rsp_rdy,
  output logic [DW-1:0]   biu2lsu_rsp_rdata,
  output logic [AW-1:0]   addr,
  input  logic [DW-1:0]   rdata,
  output logic [DW-1:0]   wdata,
  output logic            wen,
  output logic [DW/8-1:0] wstrb
);

  localparam int unsigned CW  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;

  logic [CW-1:0] ifu_cnt, lsu_cnt;
  logic [CW-1:0] ifu_infl_q, ifu_infl_d;
  logic [CW-1:0] lsu_infl_q, lsu_infl_d;
  ch_e           last_q, last_d;
  tag_t          tag_q [MEM_LAT];
  tag_t          tag_new, tag_out;
  logic          ifu_req, lsu_req, ifu_gnt, lsu_gnt;
  logic          ifu_push, lsu_push;
  logic [DW-1:0] push_data, ifu_head, lsu_head;

  // A channel may request only while buffered + in-flight responses leave room.
  assign ifu_req = !rst && ifu2biu_req_vld &&
                   ((CW1'(ifu_cnt) + CW1'(ifu_infl_q)) < CW1'(RSP_DEPTH));
  assign lsu_req = !rst && lsu2biu_req_vld &&
                   ((CW1'(lsu_cnt) + CW1'(lsu_infl_q)) < CW1'(RSP_DEPTH));

  // On a tie the channel not granted last wins.
  assign lsu_gnt = lsu_req && (!ifu_req || (last_q == CH_IFU));
  assign ifu_gnt = ifu_req && !lsu_gnt;

  assign ifu2biu_req_rdy = ifu_gnt;
  assign lsu2biu_req_rdy = lsu_gnt;

  // Memory port carries the winner; everything is zero when nothing transfers.
  assign addr  = lsu_gnt ? lsu2biu_req_addr : (ifu_gnt ? ifu2biu_req_pc : '0);
  assign wen   = lsu_gnt && lsu2biu_req_wen;
  assign wdata = lsu_gnt ? lsu2biu_req_wdata : '0;
  assign wstrb = lsu_gnt ? lsu2biu_req_wstrb : '0;

  assign tag_new = '{vld: ifu_gnt || lsu_gnt,
                     ch: (lsu_gnt ? CH_LSU : CH_IFU),
                     is_write: wen};

  // The tag leaves the pipe in the cycle its rdata is valid.
  assign tag_out   = tag_q[MEM_LAT-1];
  assign ifu_push  = tag_out.vld && (tag_out.ch == CH_IFU);
  assign lsu_push  = tag_out.vld && (tag_out.ch == CH_LSU);
  assign push_data = tag_out.is_write ? '0 : rdata;

  // In-flight counters and round-robin pointer next state.
  always_comb begin
    ifu_infl_d = ifu_infl_q;
    lsu_infl_d = lsu_infl_q;
    last_d     = last_q;
    if (ifu_gnt)  ifu_infl_d = ifu_infl_d + CW'(1);
    if (ifu_push) ifu_infl_d = ifu_infl_d - CW'(1);
    if (lsu_gnt)  lsu_infl_d = lsu_infl_d + CW'(1);
    if (lsu_push) lsu_infl_d = lsu_infl_d - CW'(1);
    if (lsu_gnt) begin
      last_d = CH_LSU;
    end else if (ifu_gnt) begin
      last_d = CH_IFU;
    end
  end

  // Reset points the round-robin at IFU so LSU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifu_infl_q <= '0;
      lsu_infl_q <= '0;
      last_q     <= CH_IFU;
      for (int i = 0; i < MEM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ifu_infl_q <= ifu_infl_d;
      lsu_infl_q <= lsu_infl_d;
      last_q     <= last_d;
      tag_q[0]   <= tag_new;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  biu_rsp_fifo #(.DW(DW), .RSP_DEPTH(RSP_DEPTH)) u_ifu_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ifu_push),
    .data_i  (push_data),
    .pop_i   (biu2ifu_rsp_vld && biu2ifu_rsp_rdy),
    .data_o  (ifu_head),
    .count_o (ifu_cnt)
  );

  biu_rsp_fifo #(.DW(DW), .RSP_DEPTH(RSP_DEPTH)) u_lsu_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (lsu_push),
    .data_i  (push_data),
    .pop_i   (biu2lsu_rsp_vld && biu2lsu_rsp_rdy),
    .data_o  (lsu_head),
    .count_o (lsu_cnt)
  );

  // Responses are suppressed while reset is held.
  assign biu2ifu_rsp_vld   = !rst && (ifu_cnt != '0);
  assign biu2ifu_rsp_inst  = rst ? '0 : ifu_head;
  assign biu2lsu_rsp_vld   = !rst && (lsu_cnt != '0);
  assign biu2lsu_rsp_rdata = rst ? '0 : lsu_head;

endmodule

// File: tb/tb_biu_arb.sv
// Self-checking bench for biu_arb with a queue-based reference model.
module tb_biu_arb;

  localparam int unsigned AW = 32, DW = 32, SW = DW / 8, LAT = 3, DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_vld, ifu_rdy, ifu_rsp_vld, ifu_rsp_rdy;
  logic [AW-1:0] pc;
  logic [DW-1:0] inst;
  logic          lsu_vld, lsu_rdy, lsu_wen, lsu_rsp_vld, lsu_rsp_rdy;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [SW-1:0] lsu_wstrb;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata, wdata;
  logic          wen;
  logic [SW-1:0] wstrb;

  biu_arb #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ifu2biu_req_vld(ifu_vld), .ifu2biu_req_rdy(ifu_rdy), .ifu2biu_req_pc(pc),
    .biu2ifu_rsp_vld(ifu_rsp_vld), .biu2ifu_rsp_rdy(ifu_rsp_rdy), .biu2ifu_rsp_inst(inst),
    .lsu2biu_req_vld(lsu_vld), .lsu2biu_req_rdy(lsu_rdy), .lsu2biu_req_addr(lsu_addr),
    .lsu2biu_req_wen(lsu_wen), .lsu2biu_req_wdata(lsu_wdata), .lsu2biu_req_wstrb(lsu_wstrb),
    .biu2lsu_rsp_vld(lsu_rsp_vld), .biu2lsu_rsp_rdy(lsu_rsp_rdy), .biu2lsu_rsp_rdata(lsu_rdata),
    .addr(addr), .rdata(rdata), .wdata(wdata), .wen(wen), .wstrb(wstrb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: per channel, every accepted-but-not-popped request is a
  // queue entry holding the cycle it becomes visible and its data.
  typedef struct { int unsigned due; logic [DW-1:0] data; } rsp_t;
  rsp_t          q_ifu[$], q_lsu[$];
  logic          last_lsu = 1'b0;
  int unsigned   cyc = 0;
  logic [AW-1:0] sched_addr [8];
  logic          sched_v    [8];

  logic          exp_ifu_rdy, exp_lsu_rdy, exp_wen, exp_ifu_vld, exp_lsu_vld;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_ifu_data, exp_lsu_data;
  logic [SW-1:0] exp_wstrb;

  function automatic logic [DW-1:0] mem_of(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'h13;
    if (a < 32'h10) return a;
    return {~a[15:0], a[15:0]} ^ 32'h0f0f_0000;
  endfunction

  task automatic model_expect();
    logic ir, lr;
    ir = !rst && ifu_vld && (q_ifu.size() < DEPTH);
    lr = !rst && lsu_vld && (q_lsu.size() < DEPTH);
    exp_lsu_rdy = lr && (!ir || !last_lsu);
    exp_ifu_rdy = ir && !exp_lsu_rdy;
    exp_addr  = exp_lsu_rdy ? lsu_addr : (exp_ifu_rdy ? pc : '0);
    exp_wen   = exp_lsu_rdy && lsu_wen;
    exp_wdata = exp_lsu_rdy ? lsu_wdata : '0;
    exp_wstrb = exp_lsu_rdy ? lsu_wstrb : '0;
    exp_ifu_vld = 1'b0; exp_ifu_data = '0;
    exp_lsu_vld = 1'b0; exp_lsu_data = '0;
    if (!rst && q_ifu.size() > 0) begin
      if (q_ifu[0].due <= cyc) begin exp_ifu_vld = 1'b1; exp_ifu_data = q_ifu[0].data; end
    end
    if (!rst && q_lsu.size() > 0) begin
      if (q_lsu[0].due <= cyc) begin exp_lsu_vld = 1'b1; exp_lsu_data = q_lsu[0].data; end
    end
  endtask

  task automatic model_update();
    rsp_t r;
    if (rst) begin
      q_ifu.delete(); q_lsu.delete(); last_lsu = 1'b0;
      for (int k = 0; k < 8; k++) sched_v[k] = 1'b0;
    end else begin
      if (exp_ifu_vld && ifu_rsp_rdy) void'(q_ifu.pop_front());
      if (exp_lsu_vld && lsu_rsp_rdy) void'(q_lsu.pop_front());
      if (exp_ifu_rdy) begin
        r.due = cyc + LAT + 1; r.data = mem_of(pc); q_ifu.push_back(r);
        sched_addr[(cyc + LAT) % 8] = pc; sched_v[(cyc + LAT) % 8] = 1'b1;
        last_lsu = 1'b0;
      end
      if (exp_lsu_rdy) begin
        r.due = cyc + LAT + 1; r.data = lsu_wen ? '0 : mem_of(lsu_addr); q_lsu.push_back(r);
        if (!lsu_wen) begin
          sched_addr[(cyc + LAT) % 8] = lsu_addr; sched_v[(cyc + LAT) % 8] = 1'b1;
        end
        last_lsu = 1'b1;
      end
    end
    sched_v[cyc % 8] = 1'b0;
    cyc++;
    rdata = sched_v[cyc % 8] ? mem_of(sched_addr[cyc % 8]) : DW'($urandom());
  endtask

  // Advance one cycle: memory and model move just after the rising edge.
  task automatic tick();
    @(posedge clk); #1;
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    ifu_vld = 0; pc = '0; ifu_rsp_rdy = 1;
    lsu_vld = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_rsp_rdy = 1;
  endtask

  task automatic do_reset(input int n);
    set_idle(); rst = 1;
    for (int i = 0; i < n; i++) begin model_expect(); #1; tick(); end
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; ifu_vld = 1; lsu_vld = 1; pc = 32'h40; lsu_addr = 32'h80; lsu_wen = 1;
    lsu_wdata = 32'hFFFF_FFFF; lsu_wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      model_expect(); #1;
      n_checks++;
      if ({ifu_rdy, lsu_rdy, wen, ifu_rsp_vld, lsu_rsp_vld} !== 5'b0)
        $display("FAIL reset_ctl: got %b want 00000", {ifu_rdy, lsu_rdy, wen, ifu_rsp_vld, lsu_rsp_vld});
      else n_pass++;
      n_checks++;
      if ((addr | wdata | inst | lsu_rdata) !== '0 || wstrb !== '0)
        $display("FAIL reset_data: addr %h wdata %h wstrb %h inst %h rdata %h want all 0",
                 addr, wdata, wstrb, inst, lsu_rdata);
      else n_pass++;
      tick();
    end
    rst = 0; set_idle(); model_expect(); #1;
    n_checks++;
    if ({ifu_rsp_vld, lsu_rsp_vld, addr} !== '0)
      $display("FAIL post_reset_idle: vld %b%b addr %h want 0", ifu_rsp_vld, lsu_rsp_vld, addr);
    else n_pass++;
    tick();
  endtask

  task automatic test_single_fetch();
    int unsigned t0; bit seen = 0;
    do_reset(1);
    ifu_vld = 1; pc = 32'h100; model_expect(); #1;
    n_checks++;
    if (ifu_rdy !== 1'b1 || addr !== 32'h100 || wen !== 1'b0 || wstrb !== '0 || wdata !== '0)
      $display("FAIL fetch_issue: rdy %b addr %h wen %b wstrb %h wdata %h want 1 100 0 0 0",
               ifu_rdy, addr, wen, wstrb, wdata);
    else n_pass++;
    t0 = cyc; tick(); ifu_vld = 0; pc = '0;
    for (int i = 0; i < LAT + 4; i++) begin
      model_expect(); #1;
      n_checks++;
      if (ifu_rsp_vld !== exp_ifu_vld || addr !== '0)
        $display("FAIL fetch_wait: vld %b addr %h want %b 0", ifu_rsp_vld, addr, exp_ifu_vld);
      else n_pass++;
      if (ifu_rsp_vld === 1'b1 && !seen) begin
        seen = 1; n_checks++;
        if (cyc != t0 + LAT + 1 || inst !== 32'h13)
          $display("FAIL fetch_rsp: cycle +%0d inst %h want +%0d 00000013", cyc - t0, inst, LAT + 1);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (!seen) $display("FAIL fetch_timeout: vld 0 want 1"); else n_pass++;
  endtask

  task automatic test_alternate();
    do_reset(1);
    ifu_vld = 1; lsu_vld = 1;
    for (int i = 0; i < 12; i++) begin
      pc = {$urandom_range(0, 255), 2'b00}; lsu_addr = $urandom();
      model_expect(); #1;
      n_checks++;
      if ({ifu_rdy, lsu_rdy} !== {exp_ifu_rdy, exp_lsu_rdy})
        $display("FAIL alt_grant[%0d]: got %b%b want %b%b", i, ifu_rdy, lsu_rdy, exp_ifu_rdy, exp_lsu_rdy);
      else n_pass++;
      if (i < 4) begin
        n_checks++;
        if (lsu_rdy !== 1'((i % 2) == 0) || ifu_rdy !== 1'((i % 2) == 1))
          $display("FAIL alt_order[%0d]: ifu %b lsu %b", i, ifu_rdy, lsu_rdy);
        else n_pass++;
      end
      if (ifu_rdy === 1'b1) begin
        n_checks++;
        if (addr !== pc || wen !== 1'b0)
          $display("FAIL alt_fetch_addr: addr %h wen %b want %h 0", addr, wen, pc);
        else n_pass++;
      end
      n_checks++;
      if ({ifu_rsp_vld, inst, lsu_rsp_vld, lsu_rdata} !== {exp_ifu_vld, exp_ifu_data, exp_lsu_vld, exp_lsu_data})
        $display("FAIL alt_rsp: ifu %b %h lsu %b %h want %b %h %b %h", ifu_rsp_vld, inst, lsu_rsp_vld,
                 lsu_rdata, exp_ifu_vld, exp_ifu_data, exp_lsu_vld, exp_lsu_data);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_ifu_backpressure();
    int ifu_acc = 0, lsu_got = 0;
    do_reset(1);
    ifu_vld = 1; ifu_rsp_rdy = 0; lsu_vld = 1;
    for (int i = 0; i < 24; i++) begin
      pc = 32'h40 + 32'(4 * i); lsu_addr = $urandom_range(0, 15); lsu_rsp_rdy = 1'($urandom_range(0, 1));
      model_expect(); #1;
      n_checks++;
      if ({ifu_rdy, lsu_rdy} !== {exp_ifu_rdy, exp_lsu_rdy})
        $display("FAIL bp_grant[%0d]: got %b%b want %b%b", i, ifu_rdy, lsu_rdy, exp_ifu_rdy, exp_lsu_rdy);
      else n_pass++;
      n_checks++;
      if ({ifu_rsp_vld, inst, lsu_rsp_vld, lsu_rdata} !== {exp_ifu_vld, exp_ifu_data, exp_lsu_vld, exp_lsu_data})
        $display("FAIL bp_rsp[%0d]: ifu %b %h lsu %b %h want %b %h %b %h", i, ifu_rsp_vld, inst,
                 lsu_rsp_vld, lsu_rdata, exp_ifu_vld, exp_ifu_data, exp_lsu_vld, exp_lsu_data);
      else n_pass++;
      if (ifu_rdy === 1'b1) ifu_acc++;
      if (lsu_rsp_vld === 1'b1 && lsu_rsp_rdy) lsu_got++;
      tick();
    end
    n_checks++;
    if (ifu_acc != 2 || lsu_got < 2)
      $display("FAIL bp_counts: ifu accepted %0d lsu returned %0d want 2 and >=2", ifu_acc, lsu_got);
    else n_pass++;
  endtask

  task automatic test_store();
    int unsigned t0; bit seen = 0;
    do_reset(1);
    lsu_vld = 1; lsu_addr = 32'h200; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
    model_expect(); #1;
    n_checks++;
    if (lsu_rdy !== 1'b1 || wen !== 1'b1 || wstrb !== 4'hF || addr !== 32'h200 || wdata !== 32'hDEAD_BEEF)
      $display("FAIL store_issue: rdy %b wen %b wstrb %h addr %h wdata %h want 1 1 f 200 deadbeef",
               lsu_rdy, wen, wstrb, addr, wdata);
    else n_pass++;
    t0 = cyc; tick(); set_idle();
    for (int i = 0; i < LAT + 4; i++) begin
      model_expect(); #1;
      if (lsu_rsp_vld === 1'b1 && !seen) begin
        seen = 1; n_checks++;
        if (cyc != t0 + LAT + 1 || lsu_rdata !== '0)
          $display("FAIL store_ack: cycle +%0d rdata %h want +%0d 0", cyc - t0, lsu_rdata, LAT + 1);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (!seen) $display("FAIL store_timeout: vld 0 want 1"); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nxt = 1, got = 0, outst = 0, max_outst = 0;
    do_reset(1);
    for (int i = 0; i < 40 && got < 4; i++) begin
      lsu_vld = (nxt <= 4); lsu_addr = AW'(nxt);
      model_expect(); #1;
      n_checks++;
      if (lsu_rdy !== exp_lsu_rdy)
        $display("FAIL b2b_rdy[%0d]: got %b want %b", i, lsu_rdy, exp_lsu_rdy);
      else n_pass++;
      if (lsu_rsp_vld === 1'b1) begin
        n_checks++;
        if (lsu_rdata !== DW'(got + 1))
          $display("FAIL b2b_data[%0d]: got %h want %h", got, lsu_rdata, got + 1);
        else n_pass++;
        got++; outst--;
      end
      if (lsu_rdy === 1'b1 && lsu_vld) begin nxt++; outst++; end
      if (outst > max_outst) max_outst = outst;
      tick();
    end
    n_checks++;
    if (got != 4 || max_outst > DEPTH)
      $display("FAIL b2b_summary: responses %0d max outstanding %0d want 4 and <=%0d", got, max_outst, DEPTH);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    int seen = 0;
    do_reset(1);
    lsu_rsp_rdy = 0;
    for (int c = 0; c < 4; c++) begin
      ifu_vld = (c == 1); pc = 32'h300; lsu_vld = (c == 0 || c == 2); lsu_addr = AW'(5 + c / 2);
      model_expect(); #1;
      n_checks++;
      if ({ifu_rdy, lsu_rdy} !== {1'(c == 1), 1'(c == 0 || c == 2)})
        $display("FAIL mid_issue[%0d]: got %b%b", c, ifu_rdy, lsu_rdy);
      else n_pass++;
      tick();
    end
    set_idle(); lsu_rsp_rdy = 0; model_expect(); #1;
    n_checks++;
    if (lsu_rsp_vld !== 1'b1 || lsu_rdata !== 32'h5 || ifu_rsp_vld !== 1'b0)
      $display("FAIL mid_buffered: lsu %b %h ifu %b want 1 5 0", lsu_rsp_vld, lsu_rdata, ifu_rsp_vld);
    else n_pass++;
    rst = 1; model_expect(); #1; tick(); rst = 0; lsu_rsp_rdy = 1;
    for (int i = 0; i < LAT + 3; i++) begin
      model_expect(); #1;
      n_checks++;
      if ({ifu_rsp_vld, lsu_rsp_vld} !== 2'b00)
        $display("FAIL mid_discard[%0d]: ifu %b lsu %b want 0 0", i, ifu_rsp_vld, lsu_rsp_vld);
      else n_pass++;
      tick();
    end
    ifu_vld = 1; pc = 32'h100; model_expect(); #1; tick(); ifu_vld = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      model_expect(); #1;
      if (ifu_rsp_vld === 1'b1) begin
        seen++; n_checks++;
        if (inst !== 32'h13) $display("FAIL mid_new_rsp: inst %h want 00000013", inst);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (seen != 1) $display("FAIL mid_new_count: got %0d responses want 1", seen); else n_pass++;
  endtask

  task automatic test_random();
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      ifu_vld = 1'($urandom_range(0, 1)); pc = $urandom(); ifu_rsp_rdy = ($urandom_range(0, 3) != 0);
      lsu_vld = 1'($urandom_range(0, 1)); lsu_addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15)) : $urandom();
      lsu_wen = 1'($urandom_range(0, 1)); lsu_wdata = $urandom(); lsu_wstrb = SW'($urandom());
      lsu_rsp_rdy = ($urandom_range(0, 3) != 0);
      model_expect(); #1;
      n_checks++;
      if ({ifu_rdy, lsu_rdy} !== {exp_ifu_rdy, exp_lsu_rdy})
        $display("FAIL rnd_grant[%0d]: got %b%b want %b%b", i, ifu_rdy, lsu_rdy, exp_ifu_rdy, exp_lsu_rdy);
      else n_pass++;
      n_checks++;
      if ({addr, wen, wdata, wstrb} !== {exp_addr, exp_wen, exp_wdata, exp_wstrb})
        $display("FAIL rnd_mem[%0d]: %h %b %h %h want %h %b %h %h", i, addr, wen, wdata, wstrb,
                 exp_addr, exp_wen, exp_wdata, exp_wstrb);
      else n_pass++;
      n_checks++;
      if ({ifu_rsp_vld, inst} !== {exp_ifu_vld, exp_ifu_data})
        $display("FAIL rnd_ifu_rsp[%0d]: %b %h want %b %h", i, ifu_rsp_vld, inst, exp_ifu_vld, exp_ifu_data);
      else n_pass++;
      n_checks++;
      if ({lsu_rsp_vld, lsu_rdata} !== {exp_lsu_vld, exp_lsu_data})
        $display("FAIL rnd_lsu_rsp[%0d]: %b %h want %b %h", i, lsu_rsp_vld, lsu_rdata, exp_lsu_vld, exp_lsu_data);
      else n_pass++;
      tick();
    end
    rst = 0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin sched_v[k] = 1'b0; sched_addr[k] = '0; end
    rst = 1; set_idle(); rdata = $urandom();
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_alternate();
    test_ifu_backpressure();
    test_store();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
